// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel coordinates, active flag, syncs, line/frame strobes and frame counter.
// All outputs are decoded from the next position and registered together with it.
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE  = 640,
   parameter int unsigned H_FP      = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BP      = 48,
   parameter int unsigned V_ACTIVE  = 480,
   parameter int unsigned V_FP      = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BP      = 33,
   parameter bit          HSYNC_POL = 1'b0,
   parameter bit          VSYNC_POL = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ce,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       active,
   output logic       hsync,
   output logic       vsync,
   output logic       line_start,
   output logic       frame_start,
   output logic [7:0] frame_count
);

   localparam int unsigned CW       = 10;
   localparam int unsigned FCW      = 8;
   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_START = H_ACTIVE + H_FP;
   localparam int unsigned HS_END   = HS_START + H_SYNC;
   localparam int unsigned VS_START = V_ACTIVE + V_FP;
   localparam int unsigned VS_END   = VS_START + V_SYNC;

   // Coordinates are 10 bits wide, so larger rasters cannot be represented
   if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_bad_timing
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
   end

   typedef enum logic {PRIME, RUN} state_t;

   state_t          state, state_n;
   logic [CW-1:0]   x_n, y_n;
   logic            active_n, hsync_n, vsync_n;
   logic            line_start_n, frame_start_n;
   logic [FCW-1:0]  frame_count_n;

   // Next position and its decodes; strobes default low so they last one clk
   always_comb begin
      state_n       = state;
      x_n           = x;
      y_n           = y;
      frame_count_n = frame_count;
      active_n      = active;
      hsync_n       = hsync;
      vsync_n       = vsync;
      line_start_n  = 1'b0;
      frame_start_n = 1'b0;
      if (ce) begin
         case (state)
            PRIME: begin
               state_n = RUN;
               x_n     = '0;
               y_n     = '0;
            end
            RUN: begin
               if (x < CW'(H_TOTAL - 1)) begin
                  x_n = x + CW'(1);
               end else begin
                  x_n = '0;
                  if (y < CW'(V_TOTAL - 1)) begin
                     y_n = y + CW'(1);
                  end else begin
                     y_n           = '0;
                     frame_count_n = frame_count + FCW'(1);
                  end
               end
            end
            default: state_n = PRIME;
         endcase
         active_n      = (x_n < CW'(H_ACTIVE)) && (y_n < CW'(V_ACTIVE));
         hsync_n       = ((x_n >= CW'(HS_START)) && (x_n < CW'(HS_END))) ? HSYNC_POL : ~HSYNC_POL;
         vsync_n       = ((y_n >= CW'(VS_START)) && (y_n < CW'(VS_END))) ? VSYNC_POL : ~VSYNC_POL;
         line_start_n  = (x_n == '0);
         frame_start_n = (x_n == '0) && (y_n == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= PRIME;
         x           <= '0;
         y           <= '0;
         active      <= 1'b0;
         hsync       <= ~HSYNC_POL;
         vsync       <= ~VSYNC_POL;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         frame_count <= '0;
      end else begin
         state       <= state_n;
         x           <= x_n;
         y           <= y_n;
         active      <= active_n;
         hsync       <= hsync_n;
         vsync       <= vsync_n;
         line_start  <= line_start_n;
         frame_start <= frame_start_n;
         frame_count <= frame_count_n;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default raster, a reduced raster for frame-level
// behaviour, and an inverted-polarity instance with default lines and short frames.
module tb_vga_timing_gen;

   logic clk;
   logic rst;
   logic ce;

   logic [9:0] d_x, d_y, s_x, s_y, p_x, p_y;
   logic       d_act, d_hs, d_vs, d_ls, d_fs;
   logic       s_act, s_hs, s_vs, s_ls, s_fs;
   logic       p_act, p_hs, p_vs, p_ls, p_fs;
   logic [7:0] d_fc, s_fc, p_fc;

   int checks = 0;
   int errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Default 640x480@60 timing
   vga_timing_gen u_def (
      .clk(clk), .rst(rst), .ce(ce), .x(d_x), .y(d_y), .active(d_act),
      .hsync(d_hs), .vsync(d_vs), .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc)
   );

   // 16x10 raster: hsync x=10..12, vsync y=7..8, active x<8 && y<6, frame = 160 ce cycles
   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
   ) u_sml (
      .clk(clk), .rst(rst), .ce(ce), .x(s_x), .y(s_y), .active(s_act),
      .hsync(s_hs), .vsync(s_vs), .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
   );

   // Positive polarity: default line (800 px), 10-line frame with vsync on lines 7..8
   vga_timing_gen #(
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
   ) u_pol (
      .clk(clk), .rst(rst), .ce(ce), .x(p_x), .y(p_y), .active(p_act),
      .hsync(p_hs), .vsync(p_vs), .line_start(p_ls), .frame_start(p_fs), .frame_count(p_fc)
   );

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int last_fs;
      int xs, ys, yp;

      rst = 1'b1;
      ce  = 1'b1;
      tick();
      tick();
      check("rst_x", int'(d_x), 0);
      check("rst_y", int'(d_y), 0);
      check("rst_active", int'(d_act), 0);
      check("rst_hsync", int'(d_hs), 1);
      check("rst_vsync", int'(d_vs), 1);
      check("rst_line_start", int'(d_ls), 0);
      check("rst_frame_start", int'(d_fs), 0);
      check("rst_frame_count", int'(d_fc), 0);
      check("pol_rst_hsync", int'(p_hs), 0);
      check("pol_rst_vsync", int'(p_vs), 0);

      // First ce after release loads (0,0)
      rst = 1'b0;
      tick();
      check("start_x", int'(d_x), 0);
      check("start_y", int'(d_y), 0);
      check("start_active", int'(d_act), 1);
      check("start_line_start", int'(d_ls), 1);
      check("start_frame_start", int'(d_fs), 1);
      check("start_frame_count", int'(d_fc), 0);
      check("start_hsync", int'(d_hs), 1);
      check("start_vsync", int'(d_vs), 1);
      check("pol_start_hsync", int'(p_hs), 0);
      check("pol_start_vsync", int'(p_vs), 0);

      // Line 0 sweep
      for (int k = 1; k < 800; k++) begin
         tick();
         check("l0_x", int'(d_x), k);
         check("l0_y", int'(d_y), 0);
         check("l0_hsync", int'(d_hs), int'(!(k >= 656 && k <= 751)));
         check("l0_active", int'(d_act), int'(k < 640));
         check("l0_line_start", int'(d_ls), 0);
         check("pol_l0_hsync", int'(p_hs), int'(k >= 656 && k <= 751));
      end
      tick();
      check("wrap_x", int'(d_x), 0);
      check("wrap_y", int'(d_y), 1);
      check("wrap_line_start", int'(d_ls), 1);
      check("wrap_frame_start", int'(d_fs), 0);

      // ce gating at (0,5)
      repeat (3199) tick();
      tick();
      check("ce_x0", int'(d_x), 0);
      check("ce_y0", int'(d_y), 5);
      check("ce_ls0", int'(d_ls), 1);
      ce = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("ce_hold_x", int'(d_x), 0);
         check("ce_hold_y", int'(d_y), 5);
         check("ce_hold_ls", int'(d_ls), 0);
         check("ce_hold_active", int'(d_act), 1);
      end
      ce = 1'b1;
      tick();
      check("ce_next_x", int'(d_x), 1);
      check("ce_next_y", int'(d_y), 5);
      check("ce_next_ls", int'(d_ls), 0);

      // Reduced raster frame behaviour
      rst = 1'b1;
      tick();
      check("rst2_x", int'(d_x), 0);
      check("rst2_y", int'(d_y), 0);
      rst = 1'b0;
      tick();
      check("sml_start_fs", int'(s_fs), 1);
      last_fs = 0;
      for (int t = 1; t <= 40960; t++) begin
         tick();
         xs = t % 16;
         ys = (t / 16) % 10;
         yp = (t / 800) % 10;
         if (t < 8000) begin
            check("sml_vsync", int'(s_vs), int'(!(ys == 7 || ys == 8)));
            check("sml_hsync", int'(s_hs), int'(!(xs >= 10 && xs <= 12)));
            check("pol_vsync", int'(p_vs), int'(yp == 7 || yp == 8));
         end
         if (t == 159) begin
            check("sml_end_x", int'(s_x), 15);
            check("sml_end_y", int'(s_y), 9);
            check("sml_end_fs", int'(s_fs), 0);
         end
         if (xs == 0 && ys == 0) begin
            check("sml_wrap_x", int'(s_x), 0);
            check("sml_wrap_y", int'(s_y), 0);
            check("sml_wrap_fs", int'(s_fs), 1);
            check("sml_wrap_fc", int'(s_fc), (t / 160) % 256);
         end
         if (s_fs) begin
            check("sml_fs_period", t - last_fs, 160);
            last_fs = t;
         end
      end
      check("sml_fc_256", int'(s_fc), 0);

      // Mid-frame reset with frame_count = 3 at (7,5)
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      repeat (567) tick();
      check("mid_x", int'(s_x), 7);
      check("mid_y", int'(s_y), 5);
      check("mid_fc", int'(s_fc), 3);
      check("mid_active", int'(s_act), 1);
      rst = 1'b1;
      tick();
      check("mrst_x", int'(s_x), 0);
      check("mrst_y", int'(s_y), 0);
      check("mrst_active", int'(s_act), 0);
      check("mrst_hsync", int'(s_hs), 1);
      check("mrst_vsync", int'(s_vs), 1);
      check("mrst_fc", int'(s_fc), 0);
      check("mrst_fs", int'(s_fs), 0);
      check("mrst_def_x", int'(d_x), 0);
      rst = 1'b0;
      tick();
      check("mrel_fs", int'(s_fs), 1);
      check("mrel_active", int'(s_act), 1);
      check("mrel_fc", int'(s_fc), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing source for the overlay pipeline.
- Produces the pixel coordinates x/y and the active flag consumed by the overlay generators (emblem, text, background), plus hsync/vsync for the output pins.
- Default timing: 640x480@60 on a ~25 MHz pixel rate, gated by a pixel clock enable.
- Also supplies line/frame strobes and a frame counter for animation.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of hsync
- VSYNC_POL, 0, asserted level of vsync

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- ce  input  1  pixel enable; timing advances only on cycles with ce=1
- x  output  10  current horizontal position, 0..H_TOTAL-1
- y  output  10  current vertical position, 0..V_TOTAL-1
- active  output  1  1 when x<H_ACTIVE and y<V_ACTIVE
- hsync  output  1  horizontal sync at HSYNC_POL when asserted
- vsync  output  1  vertical sync at VSYNC_POL when asserted
- line_start  output  1  one-ce-cycle strobe when x==0
- frame_start  output  1  one-ce-cycle strobe when x==0 and y==0
- frame_count  output  8  frames started since reset, mod 256

Behaviour:
- Interface: one clock `clk`; reset is `rst`, synchronous, active-high.
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
  - Both must be <=1024; violation is a static elaboration error.
- All outputs are registered. Decodes are computed from the next position and registered together with it, so x, y, active, hsync, vsync and the strobes are always mutually aligned (zero skew).
- FSM, two states:
  - PRIME (reset state): outputs hold reset values. On the first cycle with ce=1, load position (0,0), go to RUN.
  - RUN: on each ce=1 cycle:
    - If x<H_TOTAL-1: x=x+1.
    - Else: x=0, and y=y+1, or y=0 if y==V_TOTAL-1.
- Reset values: x=0, y=0, active=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, line_start=0, frame_start=0, frame_count=0, state=PRIME.
- rst=1 on any cycle, including mid-frame and with ce=1, forces reset values on the next edge. rst has priority over ce.
- Decodes for the loaded position (px,py):
  - active = (px<H_ACTIVE)&&(py<V_ACTIVE).
  - hsync = HSYNC_POL when H_ACTIVE+H_FP <= px < H_ACTIVE+H_FP+H_SYNC (656..751), else inverted.
  - vsync = VSYNC_POL when V_ACTIVE+V_FP <= py < V_ACTIVE+V_FP+V_SYNC (490..491), else inverted. vsync is a function of line only and changes when x wraps to 0.
  - line_start = (px==0).
  - frame_start = (px==0 && py==0).
- Strobe width:
  - Strobes last exactly one clk cycle, even though the position holds across ce=0 cycles.
  - On a cycle with ce=0, line_start and frame_start clear to 0.
  - All other outputs hold.
- frame_count:
  - Increments by 1 (8-bit wrap, 255->0) on each RUN-state wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0).
  - The PRIME->RUN load does not increment, so the first frame after reset reads 0.
- Frame period: exactly H_TOTAL*V_TOTAL = 420000 ce cycles between consecutive frame_start strobes.
- No combinational path from inputs to outputs.

Test Plan:
- Reset start: rst=1 for 2 cycles, release, ce=1 continuous.
  - Cycle after release: x=0, y=0, active=1, line_start=1, frame_start=1, frame_count=0, hsync=1, vsync=1.
- hsync window: ce=1, observe line 0.
  - hsync=0 exactly for x=656..751.
  - active=0 for x>=640.
  - x=799 is followed by x=0, y=1, line_start=1.
- Frame wrap, ce=1 continuous:
  - vsync=0 exactly on lines 490 and 491.
  - (799,524) is followed by (0,0), frame_start=1, frame_count=1.
  - Consecutive frame_start strobes are 420000 cycles apart.
  - After 256 frames, frame_count=0.
- ce gating: ce toggles 1,0,0,1 starting at (0,5).
  - Position holds at (0,5) for 2 cycles.
  - line_start is high only on the first cycle.
  - Next ce cycle gives x=1.
- Mid-frame reset: at (300,200) with frame_count=3, assert rst=1 with ce=1.
  - Next cycle: x=0, y=0, active=0, syncs inactive, frame_count=0.
  - After release plus one ce cycle, frame_start=1.
- Polarity: HSYNC_POL=1, VSYNC_POL=1.
  - hsync=1 only for x=656..751.
  - vsync=1 only for y=490..491.
  - Both are 0 in reset.
